// File: rtl/ifetch_pkg.sv
// ifetch_pkg: definitions shared by the instruction fetch stage.
//   fetch_state_e : fetch FSM states (LOOKUP, MISS, FILL)
//   XLEN          : address / instruction width in bits
//   INST_BYTES    : bytes per instruction, which is the PC increment
package ifetch_pkg;

    localparam int XLEN       = 32;
    localparam int INST_BYTES = 4;

    typedef enum logic [1:0] {
        LOOKUP,
        MISS,
        FILL
    } fetch_state_e;

endpackage

// File: rtl/ifetch.sv
// ifetch: instruction fetch stage in front of a direct-mapped icache.
// The stage owns the PC and looks up each PC in the icache. On a miss it
// reads the word from the memory bus and writes it into the icache. The
// following lookup then hits. Instructions go to decode through a one-entry
// valid/ready output register. A redirect reloads the PC and flushes that
// register.
//
// Ports:
//   clock, reset           : system clock; asynchronous active-high reset
//   cache_addr             : lookup address (pc) or fill address (miss_addr)
//   cache_hit, cache_rdata : combinational icache lookup result
//   cache_wen, cache_wdata : one-cycle icache fill strobe and data
//   mem_req, mem_addr      : memory read request, held until mem_ack
//   mem_ack, mem_rdata     : one-cycle memory response
//   redirect, redirect_pc  : PC reload from execute; low two bits forced to 0
//   inst_valid, inst_ready : handshake with decode
//   inst, inst_pc          : instruction word and its PC
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic            clock,
    input  logic            reset,

    output logic [XLEN-1:0] cache_addr,
    input  logic            cache_hit,
    input  logic [XLEN-1:0] cache_rdata,
    output logic            cache_wen,
    output logic [XLEN-1:0] cache_wdata,

    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,

    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,

    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc
);

    fetch_state_e    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] miss_addr;
    logic [XLEN-1:0] fill_data;

    logic            slot_free;
    logic            transfer;
    logic            unused_redirect_bits;

    // The output register can take a new instruction when it is empty or
    // when decode drains it in this same cycle.
    assign slot_free = !inst_valid || inst_ready;
    assign transfer  = inst_valid && inst_ready;

    // In MISS the icache sees miss_addr with cache_wen low. The icache
    // ignores that lookup, and the address is already correct for FILL.
    assign cache_addr  = (state == LOOKUP) ? pc : miss_addr;
    assign cache_wdata = fill_data;
    assign mem_addr    = miss_addr;

    // Redirect targets are word aligned, so the low bits are dropped.
    assign unused_redirect_bits = ^redirect_pc[1:0];

    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples pre-edge values, and a later assignment in this block
    // overrides an earlier one. The redirect override at the bottom relies
    // on that ordering.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= LOOKUP;
            pc         <= RESET_PC;
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
            mem_req    <= 1'b0;
            cache_wen  <= 1'b0;
            miss_addr  <= '0;
            fill_data  <= '0;
        end else begin
            // A drained slot empties unless a new hit refills it below.
            if (transfer) begin
                inst_valid <= 1'b0;
            end

            case (state)
                LOOKUP: begin
                    if (redirect) begin
                        // Redirect wins over both a hit and a miss.
                    end else if (cache_hit) begin
                        if (slot_free) begin
                            inst       <= cache_rdata;
                            inst_pc    <= pc;
                            inst_valid <= 1'b1;
                            pc         <= pc + XLEN'(INST_BYTES);
                        end
                    end else begin
                        miss_addr <= pc;
                        mem_req   <= 1'b1;
                        state     <= MISS;
                    end
                end

                MISS: begin
                    // The request is never abandoned, even after a redirect.
                    // The returning data is still correct for miss_addr.
                    if (mem_ack) begin
                        fill_data <= mem_rdata;
                        mem_req   <= 1'b0;
                        cache_wen <= 1'b1;
                        state     <= FILL;
                    end
                end

                FILL: begin
                    cache_wen <= 1'b0;
                    state     <= LOOKUP;
                end

                default: begin
                    mem_req   <= 1'b0;
                    cache_wen <= 1'b0;
                    state     <= LOOKUP;
                end
            endcase

            // A redirect in any state reloads pc and flushes the output slot.
            // A pending miss or fill still completes. The next LOOKUP then
            // uses the new pc.
            if (redirect) begin
                pc         <= {redirect_pc[XLEN-1:2], 2'b00};
                inst_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed test of ifetch. The stimulus process pushes the
// expected (inst, inst_pc) pairs into a queue. A separate monitor pops one
// pair on every decode transfer and compares it with the DUT output. The
// icache is a small behavioural model that also has a force-hit mode.
module tb_ifetch;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] cache_addr;
    logic        cache_hit;
    logic [31:0] cache_rdata;
    logic        cache_wen;
    logic [31:0] cache_wdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack     = 1'b0;
    logic [31:0] mem_rdata   = '0;
    logic        redirect    = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready  = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    ifetch #(.RESET_PC(32'h8000_0000)) dut (
        .clock       (clock),
        .reset       (reset),
        .cache_addr  (cache_addr),
        .cache_hit   (cache_hit),
        .cache_rdata (cache_rdata),
        .cache_wen   (cache_wen),
        .cache_wdata (cache_wdata),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc)
    );

    always #5 clock = ~clock;

    // ---------------- icache model ----------------
    logic        hit_all = 1'b0;  // every lookup hits
    logic        hit_xor = 1'b0;  // forced data = addr ^ 0x13, else 0x13
    logic        flush   = 1'b0;
    logic [31:0] tag_q [8];
    logic [31:0] dat_q [8];
    logic        vld_q [8];

    always_comb begin
        cache_hit   = 1'b0;
        cache_rdata = '0;
        if (hit_all) begin
            cache_hit   = 1'b1;
            cache_rdata = hit_xor ? (cache_addr ^ 32'h0000_0013) : 32'h0000_0013;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (vld_q[i] && tag_q[i] == cache_addr) begin
                    cache_hit   = 1'b1;
                    cache_rdata = dat_q[i];
                end
            end
        end
    end

    always @(posedge clock) begin
        if (flush) begin
            for (int i = 0; i < 8; i++) vld_q[i] <= 1'b0;
        end else if (cache_wen) begin
            tag_q[cache_addr[4:2]] <= cache_addr;
            dat_q[cache_addr[4:2]] <= cache_wdata;
            vld_q[cache_addr[4:2]] <= 1'b1;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic mon_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic push(input logic [31:0] i, input logic [31:0] p);
        exp_t e;
        e.inst = i;
        e.pc   = p;
        exp_q.push_back(e);
    endtask

    always @(negedge clock) begin
        if (mon_en && inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_unexpected: got inst_pc %h inst %h with nothing expected", inst_pc, inst);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_inst", inst, e.inst);
                check("sb_inst_pc", inst_pc, e.pc);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic hold_reset();
        reset       = 1'b1;
        mem_ack     = 1'b0;
        redirect    = 1'b0;
        inst_ready  = 1'b0;
        mon_en      = 1'b0;
        flush       = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        flush       = 1'b0;
    endtask

    task automatic end_test(input string name);
        @(negedge clock);
        #1;
        mon_en = 1'b0;
        check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        // T1: reset values, then back-to-back hits
        hit_all = 1'b1;
        hit_xor = 1'b0;
        hold_reset();
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst",       inst,            32'h0);
        check("rst_inst_pc",    inst_pc,         32'h0);
        check("rst_mem_req",    32'(mem_req),    32'd0);
        check("rst_cache_wen",  32'(cache_wen),  32'd0);
        check("rst_cache_addr", cache_addr,      32'h8000_0000);
        push(32'h0000_0013, 32'h8000_0000);
        push(32'h0000_0013, 32'h8000_0004);
        push(32'h0000_0013, 32'h8000_0008);
        inst_ready = 1'b1;
        mon_en     = 1'b1;
        reset      = 1'b0;
        check("t1_valid_c0", 32'(inst_valid), 32'd0);
        tick();
        check("t1_valid_c1", 32'(inst_valid), 32'd1);
        tick();
        check("t1_pc_c2", inst_pc, 32'h8000_0004);
        tick();
        check("t1_pc_c3", inst_pc, 32'h8000_0008);
        end_test("t1");

        // T2: miss, ack two cycles after the request, fill, hit
        hit_all = 1'b0;
        hold_reset();
        push(32'hDEAD_BEEF, 32'h8000_0000);
        inst_ready = 1'b1;
        mon_en     = 1'b1;
        reset      = 1'b0;
        check("t2_req_c0", 32'(mem_req), 32'd0);
        tick();
        check("t2_req_c1",  32'(mem_req), 32'd1);
        check("t2_addr_c1", mem_addr,     32'h8000_0000);
        tick();
        check("t2_req_c2",  32'(mem_req), 32'd1);
        check("t2_addr_c2", mem_addr,     32'h8000_0000);
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ack = 1'b0;
        check("t2_wen_fill",   32'(cache_wen), 32'd1);
        check("t2_wdata_fill", cache_wdata,    32'hDEAD_BEEF);
        check("t2_caddr_fill", cache_addr,     32'h8000_0000);
        check("t2_req_fill",   32'(mem_req),   32'd0);
        tick();
        check("t2_wen_after",   32'(cache_wen),  32'd0);
        check("t2_valid_relook", 32'(inst_valid), 32'd0);
        tick();
        check("t2_valid_out", 32'(inst_valid), 32'd1);
        end_test("t2");

        // T3: output stall with continuous hits
        hit_all = 1'b1;
        hit_xor = 1'b1;
        hold_reset();
        reset = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("t3_stall_valid", 32'(inst_valid), 32'd1);
            check("t3_stall_inst",  inst,            32'h8000_0013);
            check("t3_stall_pc",    inst_pc,         32'h8000_0000);
            check("t3_stall_fetch", cache_addr,      32'h8000_0004);
            tick();
        end
        push(32'h8000_0013, 32'h8000_0000);
        push(32'h8000_0017, 32'h8000_0004);
        inst_ready = 1'b1;
        mon_en     = 1'b1;
        tick();
        check("t3_next_pc", inst_pc, 32'h8000_0004);
        end_test("t3");

        // T4: redirect while a miss is outstanding
        hit_all = 1'b0;
        hit_xor = 1'b0;
        hold_reset();
        inst_ready  = 1'b1;
        mon_en      = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h8000_0010;
        reset       = 1'b0;
        tick();
        redirect = 1'b0;
        check("t4_lookup_addr", cache_addr,      32'h8000_0010);
        check("t4_valid_c1",    32'(inst_valid), 32'd0);
        tick();
        check("t4_req_c2",  32'(mem_req), 32'd1);
        check("t4_addr_c2", mem_addr,     32'h8000_0010);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0102;
        tick();
        redirect = 1'b0;
        check("t4_req_kept",   32'(mem_req),    32'd1);
        check("t4_addr_kept",  mem_addr,        32'h8000_0010);
        check("t4_caddr_miss", cache_addr,      32'h8000_0010);
        check("t4_wen_miss",   32'(cache_wen),  32'd0);
        check("t4_valid_miss", 32'(inst_valid), 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_ack = 1'b0;
        check("t4_wen_fill",   32'(cache_wen),  32'd1);
        check("t4_caddr_fill", cache_addr,      32'h8000_0010);
        check("t4_wdata_fill", cache_wdata,     32'hCAFE_F00D);
        check("t4_req_fill",   32'(mem_req),    32'd0);
        check("t4_valid_fill", 32'(inst_valid), 32'd0);
        tick();
        check("t4_new_lookup", cache_addr,      32'h0000_0100);
        check("t4_wen_done",   32'(cache_wen),  32'd0);
        check("t4_valid_look", 32'(inst_valid), 32'd0);
        push(32'h0000_0113, 32'h0000_0100);
        hit_all = 1'b1;
        hit_xor = 1'b1;
        tick();
        check("t4_valid_hit", 32'(inst_valid), 32'd1);
        end_test("t4");

        // T5: redirect to the top word, wrap to 0, redirect on a hit
        hit_all = 1'b1;
        hit_xor = 1'b1;
        hold_reset();
        push(32'hFFFF_FFEF, 32'hFFFF_FFFC);
        push(32'h0000_0013, 32'h0000_0000);
        inst_ready  = 1'b1;
        mon_en      = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        reset       = 1'b0;
        tick();
        redirect = 1'b0;
        check("t5_no_capture", 32'(inst_valid), 32'd0);
        check("t5_aligned_pc", cache_addr,      32'hFFFF_FFFC);
        tick();
        check("t5_top_pc", inst_pc, 32'hFFFF_FFFC);
        tick();
        check("t5_wrap_pc", inst_pc, 32'h0000_0000);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        check("t5_flush_valid", 32'(inst_valid), 32'd0);
        check("t5_redir_addr",  cache_addr,      32'h0000_0200);
        end_test("t5");

        // T6: reset asserted while a request is outstanding
        hit_all = 1'b0;
        hit_xor = 1'b0;
        hold_reset();
        reset = 1'b0;
        tick();
        check("t6_req_before", 32'(mem_req), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_req_async",   32'(mem_req),    32'd0);
        check("t6_valid_async", 32'(inst_valid), 32'd0);
        check("t6_wen_async",   32'(cache_wen),  32'd0);
        check("t6_caddr_async", cache_addr,      32'h8000_0000);
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("t6_req_release", 32'(mem_req), 32'd0);
        check("t6_lookup_addr", cache_addr,   32'h8000_0000);
        tick();
        check("t6_req_again",  32'(mem_req), 32'd1);
        check("t6_addr_again", mem_addr,     32'h8000_0000);

        hold_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
